axis_testpattern_burst_ctrl: RTL and testbench

Sequencer that sits between an `axis_testpattern_generator` instance and the downstream AXI-Stream sink. It gates the generator's stream into a programmed number of fixed-length bursts separated by idle gaps, drives the generator's `enable`, inserts `tlast` on each burst's final beat, and reports completion. Data passes through combinationally; the controller only gates handshakes and counts beats.

---
 rtl/axis_tpg_pkg.sv | 15 +
 rtl/axis_testpattern_burst_ctrl.sv | 162 ++++++++++++++++
 tb/tb_axis_testpattern_burst_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_tpg_pkg.sv
// rtl/axis_tpg_pkg.sv - shared types and default widths for the test-pattern burst controller
package axis_tpg_pkg;

    localparam int TDATA_WIDTH_DEF = 24;
    localparam int LEN_WIDTH_DEF   = 16;
    localparam int CNT_WIDTH_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } tpg_state_e;

endpackage

// File: rtl/axis_testpattern_burst_ctrl.sv
// rtl/axis_testpattern_burst_ctrl.sv - gates a pattern generator stream into counted bursts with idle gaps
module axis_testpattern_burst_ctrl
    import axis_tpg_pkg::*;
#(
    parameter int TDATA_WIDTH = TDATA_WIDTH_DEF,
    parameter int LEN_WIDTH   = LEN_WIDTH_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                   m_axis_aclk,
    input  logic                   m_axis_aresetn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [LEN_WIDTH-1:0]   burst_len,
    input  logic [CNT_WIDTH-1:0]   burst_count,
    input  logic [LEN_WIDTH-1:0]   gap_cycles,
    output logic                   gen_enable,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    tpg_state_e state_q, state_d;

    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] gap_q, gap_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [LEN_WIDTH-1:0] beat_q, beat_d;
    logic [LEN_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0] burst_q, burst_d;

    logic run;
    logic in_gap;
    logic hs;
    logic last_beat;
    logic last_burst;
    logic start_ok;

    assign run        = (state_q == ST_RUN);
    assign in_gap     = (state_q == ST_GAP);
    assign hs         = m_axis_tvalid & m_axis_tready;
    assign last_beat  = (beat_q == (len_q - LEN_ONE));
    // count_q == 0 selects free-running mode, so the burst index never ends the run
    assign last_burst = (count_q != '0) && (burst_q == (count_q - CNT_ONE));
    assign start_ok   = start && (burst_len != '0);

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hs && last_beat) begin
                    if (last_burst) begin
                        state_d = ST_DONE;
                    end else if (gap_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q == LEN_ONE) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        len_d     = len_q;
        gap_d     = gap_q;
        count_d   = count_q;
        beat_d    = beat_q;
        gap_cnt_d = gap_cnt_q;
        burst_d   = burst_q;
        if (state_q == ST_IDLE) begin
            if (start_ok) begin
                len_d     = burst_len;
                gap_d     = gap_cycles;
                count_d   = burst_count;
                beat_d    = '0;
                gap_cnt_d = '0;
                burst_d   = '0;
            end
        end else if (run) begin
            if (hs) begin
                if (last_beat) begin
                    beat_d    = '0;
                    burst_d   = burst_q + CNT_ONE;
                    gap_cnt_d = gap_q;
                end else begin
                    beat_d = beat_q + LEN_ONE;
                end
            end
        end else if (in_gap) begin
            gap_cnt_d = gap_cnt_q - LEN_ONE;
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            len_q     <= '0;
            gap_q     <= '0;
            count_q   <= '0;
            beat_q    <= '0;
            gap_cnt_q <= '0;
            burst_q   <= '0;
        end else begin
            len_q     <= len_d;
            gap_q     <= gap_d;
            count_q   <= count_d;
            beat_q    <= beat_d;
            gap_cnt_q <= gap_cnt_d;
            burst_q   <= burst_d;
        end
    end

    // Everything below is combinational from state, so an async reset silences the stream at once
    always_comb begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid & run;
        s_axis_tready = m_axis_tready & run;
        m_axis_tlast  = run & last_beat;
        gen_enable    = run;
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_DONE);
        aborted       = abort & (run | in_gap);
    end

endmodule

// File: tb/tb_axis_testpattern_burst_ctrl.sv
// tb/tb_axis_testpattern_burst_ctrl.sv - self-checking bench for axis_testpattern_burst_ctrl
module tb_axis_testpattern_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [15:0] burst_len, gap_cycles;
    logic [15:0] burst_count;
    logic        gen_enable;
    logic [23:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic        busy, done, aborted;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gen_val;
    bit gen_vld;
    bit rnd;
    int hs_data[$];
    bit hs_last[$];
    int hs_cyc[$];
    int done_n, done_cyc, off_n;

    always #5 clk = ~clk;

    axis_testpattern_burst_ctrl dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .start          (start),
        .abort          (abort),
        .burst_len      (burst_len),
        .burst_count    (burst_count),
        .gap_cycles     (gap_cycles),
        .gen_enable     (gen_enable),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Generator model: counts 1..10 and wraps, advancing only on an accepted beat
    task automatic tick();
        bit g_hs;
        @(negedge clk);
        g_hs = s_axis_tvalid && s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
            hs_data.push_back(int'(m_axis_tdata));
            hs_last.push_back(m_axis_tlast);
            hs_cyc.push_back(cyc);
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (busy && !gen_enable) off_n++;
        @(posedge clk);
        #1;
        cyc++;
        if (g_hs) gen_val = (gen_val == 10) ? 1 : gen_val + 1;
        if (rnd) begin
            gen_vld       = (gen_vld && !g_hs) ? 1'b1 : ($urandom_range(3) != 0);
            m_axis_tready = ($urandom_range(3) != 0);
        end
        s_axis_tdata  = 24'(gen_val);
        s_axis_tvalid = gen_vld;
    endtask

    task automatic clear_mon();
        hs_data.delete();
        hs_last.delete();
        hs_cyc.delete();
        done_n  = 0;
        done_cyc = -1;
        off_n   = 0;
        gen_val = 1;
        gen_vld = 1'b1;
        s_axis_tdata  = 24'd1;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run_seq(input int len, input int count, input int gap, input bit stall, input bit noise);
        int c_start;
        int t;
        bit stalled;
        clear_mon();
        burst_len   = 16'(len);
        burst_count = 16'(count);
        gap_cycles  = 16'(gap);
        c_start = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_gen_enable", gen_enable, 1'b1);
        t = 0;
        stalled = 0;
        while (done_n == 0 && t < 2000) begin
            if (noise) begin
                burst_len   = 16'($urandom_range(9));
                burst_count = 16'($urandom_range(5));
                gap_cycles  = 16'($urandom_range(5));
                start       = ($urandom_range(7) == 0);
            end
            tick();
            t++;
            if (stall && !stalled && hs_data.size() == 2) begin
                stalled = 1;
                m_axis_tready = 1'b0;
                repeat (5) begin
                    #1;
                    chk("stall_s_tready", s_axis_tready, 1'b0);
                    chk("stall_data_held", m_axis_tdata, 24'd3);
                    tick();
                end
                m_axis_tready = 1'b1;
            end
        end
        start = 1'b0;
        chk("done_seen", done_n > 0, 1'b1);
        tick();
        chk("idle_after_done", busy, 1'b0);
        chk("done_one_cycle", done, 1'b0);
        chk("beat_total", hs_data.size(), len * count);
        for (int k = 0; k < hs_data.size(); k++) begin
            chk("beat_data", hs_data[k], (k % 10) + 1);
            chk("beat_last", hs_last[k], (k % len) == (len - 1));
        end
        chk("done_pulses", done_n, 1);
        if (hs_cyc.size() > 0) chk("done_latency", done_cyc, hs_cyc[hs_cyc.size()-1] + 1);
        chk("idle_cycles_total", off_n, gap * (count - 1) + 1);
        if (!rnd && hs_cyc.size() == len * count) begin
            if (!stall) chk("start_latency", hs_cyc[0], c_start + 1);
            for (int b = 1; b < count; b++)
                chk("gap_length", hs_cyc[b*len] - hs_cyc[b*len-1], gap + 1);
        end
    endtask

    initial begin
        rnd = 0;
        clear_mon();
        burst_len = 16'd0;
        burst_count = 16'd0;
        gap_cycles = 16'd0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_gen_enable", gen_enable, 1'b0);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        tick();

        // start with zero length is dropped
        burst_len = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_busy", busy, 1'b0);
        chk("len0_gen_enable", gen_enable, 1'b0);

        // abort while idle is ignored
        abort = 1'b1;
        #1;
        chk("abort_idle", aborted, 1'b0);
        tick();
        abort = 1'b0;
        chk("abort_idle_busy", busy, 1'b0);

        run_seq(4, 2, 3, 0, 0);
        run_seq(4, 2, 3, 1, 0);
        run_seq(3, 3, 0, 0, 0);
        run_seq(4, 2, 3, 0, 1);

        // abort on beat 6 of a free-running sequence
        clear_mon();
        burst_len = 16'd4;
        burst_count = 16'd0;
        gap_cycles = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 100 && hs_data.size() < 5; t++) tick();
        chk("abort_reach_beat5", hs_data.size(), 5);
        abort = 1'b1;
        #1;
        chk("abort_pulse", aborted, 1'b1);
        chk("abort_tlast", m_axis_tlast, 1'b0);
        chk("abort_beat_data", m_axis_tdata, 24'd6);
        tick();
        abort = 1'b0;
        chk("abort_idle_next", busy, 1'b0);
        chk("abort_gen_off", gen_enable, 1'b0);
        chk("abort_pulse_end", aborted, 1'b0);
        repeat (6) tick();
        chk("abort_beats", hs_data.size(), 6);
        chk("abort_no_done", done_n, 0);

        // async reset while beat 2 is on the bus
        clear_mon();
        burst_len = 16'd4;
        burst_count = 16'd2;
        gap_cycles = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 50 && hs_data.size() < 1; t++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gen_enable", gen_enable, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("mid_rst_s_tready", s_axis_tready, 1'b0);
        chk("mid_rst_tlast", m_axis_tlast, 1'b0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_idle", busy, 1'b0);
        chk("post_rst_beats", hs_data.size(), 1);
        chk("post_rst_no_done", done_n, 0);

        // randomized configs with random valid/ready and stray starts
        rnd = 1;
        for (int r = 0; r < 8; r++)
            run_seq($urandom_range(5, 1), $urandom_range(4, 1), $urandom_range(4), 0, 1);
        rnd = 0;
        run_seq(1, 3, 2, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
